// File: rtl/sfp_bank.sv
// Banked accumulate / ReLU post-processor with a single-slot valid/ready output stage.
// Define SFP_SAT_EN for saturating lane adds; leave it undefined for two's-complement wrap-around.
module sfp_bank #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in,
  input  logic [addr_bw-1:0]       addr_in,
  input  logic                     acc_en,
  input  logic                     last,
  input  logic                     relu_en,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [psum_bw*col-1:0]   out,
  output logic [addr_bw-1:0]       addr_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     ovf
);

  localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw*col-1:0] mem [depth];
  logic [psum_bw*col-1:0] rd_vec;
  logic [psum_bw*col-1:0] sum_vec;
  logic [psum_bw*col-1:0] emit_vec;
  logic [col-1:0]         lane_ovf;
  logic                   accept;

  // One output slot, no skid buffer: a stalled output blocks every input beat.
  assign ready_in = !valid_out || ready_out;
  assign accept   = valid_in && ready_in;

  // Combinational read so back-to-back beats to one entry see the value written on the previous edge.
  assign rd_vec = mem[addr_in];

  always_comb begin
    logic [psum_bw-1:0] a;
    logic [psum_bw-1:0] b;
    logic [psum_bw-1:0] s;
    logic [psum_bw:0]   wide;
    sum_vec  = '0;
    emit_vec = '0;
    lane_ovf = '0;
    a        = '0;
    b        = '0;
    s        = '0;
    wide     = '0;
    for (int k = 0; k < col; k++) begin
      a    = rd_vec[psum_bw*k +: psum_bw];
      b    = in[psum_bw*k +: psum_bw];
      wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      s    = b;
      if (acc_en) begin
        // Sign-extended sum whose top two bits disagree has left the signed range.
        lane_ovf[k] = wide[psum_bw] ^ wide[psum_bw-1];
`ifdef SFP_SAT_EN
        if (lane_ovf[k]) begin
          s = wide[psum_bw] ? lane_min : lane_max;
        end else begin
          s = wide[psum_bw-1:0];
        end
`else
        s = wide[psum_bw-1:0];
`endif
      end
      sum_vec[psum_bw*k +: psum_bw]  = s;
      emit_vec[psum_bw*k +: psum_bw] = (relu_en && s[psum_bw-1]) ? '0 : s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[addr_in] <= sum_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      addr_out  <= '0;
      valid_out <= 1'b0;
    end else if (accept && last) begin
      out       <= emit_vec;
      addr_out  <= addr_in;
      valid_out <= 1'b1;
    end else if (valid_out && ready_out) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (accept && (|lane_ovf)) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_bank.sv
// Directed bench for sfp_bank: a reference model pushes expected outputs to a scoreboard queue,
// and a monitor pops and compares them on every output transfer.
module tb_sfp_bank;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk;
  logic              reset;
  logic [BW*COL-1:0] in_data;
  logic [AW-1:0]     addr_in;
  logic              acc_en;
  logic              last;
  logic              relu_en;
  logic              valid_in;
  logic              ready_in;
  logic [BW*COL-1:0] out_data;
  logic [AW-1:0]     addr_out;
  logic              valid_out;
  logic              ready_out;
  logic              ovf;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [BW*COL-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   model_mem [DEPTH][COL];
  logic model_ovf;
  int   n_checks;
  int   n_errors;

  sfp_bank #(.col(COL), .psum_bw(BW), .depth(DEPTH), .addr_bw(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_data),
    .addr_in   (addr_in),
    .acc_en    (acc_en),
    .last      (last),
    .relu_en   (relu_en),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .out       (out_data),
    .addr_out  (addr_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW*COL-1:0] vec(int base, int step);
    logic [BW*COL-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      v = base + k * step;
      r[BW*k +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  task automatic check_output(string tag, logic [BW*COL-1:0] obs, logic [BW*COL-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < COL; k++)
        model_mem[i][k] = 0;
    model_ovf = 1'b0;
  endtask

  // Reference model of one accepted beat, using plain integer arithmetic.
  task automatic model_beat(logic [AW-1:0] a, logic [BW*COL-1:0] d, logic acc, logic lst, logic relu);
    exp_t e;
    logic signed [BW-1:0] lane;
    int s;
    int emit;
    e.addr = a;
    e.data = '0;
    for (int k = 0; k < COL; k++) begin
      lane = d[BW*k +: BW];
      s = acc ? model_mem[a][k] + int'(lane) : int'(lane);
      if (s > 32767) begin
        model_ovf = 1'b1;
`ifdef SFP_SAT_EN
        s = 32767;
`else
        s = s - 65536;
`endif
      end else if (s < -32768) begin
        model_ovf = 1'b1;
`ifdef SFP_SAT_EN
        s = -32768;
`else
        s = s + 65536;
`endif
      end
      model_mem[a][k] = s;
      emit = (relu && s < 0) ? 0 : s;
      e.data[BW*k +: BW] = emit[BW-1:0];
    end
    if (lst) sb.push_back(e);
  endtask

  // Drives one beat, waits (bounded) for acceptance, and leaves inputs driven at posedge+1.
  task automatic apply_stimulus(logic [AW-1:0] a, logic [BW*COL-1:0] d, logic acc, logic lst, logic relu);
    int waited;
    addr_in  = a;
    in_data  = d;
    acc_en   = acc;
    last     = lst;
    relu_en  = relu;
    valid_in = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!ready_in && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (ready_in) begin
      model_beat(a, d, acc, lst, relu);
    end else begin
      check_output("accept_timeout", ready_in, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    valid_in = 1'b0;
    last     = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && valid_out && ready_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("[TB] FAIL unexpected_output: observed addr %0d expected no output", addr_out);
      end else begin
        e = sb.pop_front();
        check_output("out", out_data, e.data);
        check_output("addr_out", addr_out, e.addr);
      end
    end
  end

  initial begin
    logic [BW*COL-1:0] held;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    in_data   = '0;
    addr_in   = '0;
    acc_en    = 1'b0;
    last      = 1'b0;
    relu_en   = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    model_reset();

    #1;
    check_output("reset_valid_out", valid_out, 1'b0);
    check_output("reset_out", out_data, '0);
    check_output("reset_addr_out", addr_out, '0);
    check_output("reset_ovf", ovf, 1'b0);
    check_output("reset_ready_in", ready_in, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);

    $display("[TB] accumulate three beats into entry 2");
    apply_stimulus(4'd2, vec(5, 1), 1'b0, 1'b0, 1'b0);
    check_output("no_valid_beat1", valid_out, 1'b0);
    apply_stimulus(4'd2, vec(7, 1), 1'b1, 1'b0, 1'b0);
    check_output("no_valid_beat2", valid_out, 1'b0);
    apply_stimulus(4'd2, vec(-3, 1), 1'b1, 1'b1, 1'b0);
    check_output("latency_valid", valid_out, 1'b1);

    $display("[TB] interleaved entries 0 and 1");
    apply_stimulus(4'd0, vec(10, 1), 1'b0, 1'b0, 1'b0);
    apply_stimulus(4'd1, vec(4, 2), 1'b0, 1'b0, 1'b0);
    apply_stimulus(4'd0, vec(1, 0), 1'b1, 1'b1, 1'b0);
    apply_stimulus(4'd1, vec(4, 0), 1'b1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] backpressure with a pending output");
    ready_out = 1'b0;
    apply_stimulus(4'd5, vec(20, 1), 1'b0, 1'b1, 1'b0);
    addr_in  = 4'd6;
    in_data  = vec(30, 1);
    acc_en   = 1'b0;
    last     = 1'b1;
    relu_en  = 1'b0;
    valid_in = 1'b1;
    held     = out_data;
    repeat (3) begin
      @(negedge clk);
      check_output("stall_ready_in", ready_in, 1'b0);
      check_output("stall_out_stable", out_data, held);
      check_output("stall_addr_out", addr_out, 4'd5);
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    @(negedge clk);
    check_output("release_ready_in", ready_in, 1'b1);
    if (ready_in) model_beat(4'd6, vec(30, 1), 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_output("release_new_valid", valid_out, 1'b1);
    idle(2);

    $display("[TB] relu on emitted value only");
    apply_stimulus(4'd4, vec(-6, 3), 1'b0, 1'b1, 1'b1);
    apply_stimulus(4'd4, vec(10, 0), 1'b1, 1'b1, 1'b1);
    idle(2);
    check_output("ovf_still_clear", ovf, 1'b0);

    $display("[TB] lane overflow");
    apply_stimulus(4'd7, vec(32767, -1000), 1'b0, 1'b0, 1'b0);
    apply_stimulus(4'd7, vec(1, 0), 1'b1, 1'b1, 1'b0);
    check_output("ovf_set", ovf, model_ovf);
    idle(2);
    check_output("ovf_sticky", ovf, 1'b1);

    $display("[TB] asynchronous reset with output pending");
    ready_out = 1'b0;
    apply_stimulus(4'd2, vec(50, 0), 1'b0, 1'b1, 1'b0);
    check_output("pre_reset_valid", valid_out, 1'b1);
    valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_output("async_valid_out", valid_out, 1'b0);
    check_output("async_out", out_data, '0);
    check_output("async_addr_out", addr_out, '0);
    check_output("async_ovf", ovf, 1'b0);
    check_output("async_ready_in", ready_in, 1'b1);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ready_out = 1'b1;
    apply_stimulus(4'd2, vec(3, 0), 1'b1, 1'b1, 1'b0);
    idle(3);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
